board_scan_reader: RTL and testbench
====================================

# board_scan_reader

Read-side sequencer for the 4x4 Sudoku datapath: on a start pulse it walks every board cell through the datapath's registered read-index port and captures each cell's user value and fill flag. It emits one formatted byte per cell on a valid/ready stream toward the display/serial path. It is the consumer of the board storage that the user-input path writes, and sits between the datapath and the output formatter.

## Interface
- NUM_CELLS, 16, cells scanned per pass (indices 0..NUM_CELLS-1); legal range 1..16
- clka  in  1  single system clock, all state on rising edge
- restart_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a scan; ignored while busy
- ridx  out  4  cell read index driven to the datapath read port
- rdata_user  in  3  user-board cell value returned for ridx, valid one cycle after ridx
- rdata_real  in  3  real-board (solution) cell value for ridx, same timing
- fill_flag  in  16  per-cell filled flags from the datapath, sampled at capture
- out_valid  out  1  stream byte valid
- out_ready  in  1  downstream accepts byte when high with out_valid
- out_data  out  8  {idx[3:0], fill_flag[idx], rdata_user[2:0]}
- out_last  out  1  high with the byte for cell NUM_CELLS-1
- busy  out  1  high from accepted start until the final byte is accepted
- done  out  1  one-cycle pulse after final byte accepted
- mismatch_cnt  out  5  filled cells whose user value differs from real value (see Configuration)

## Operation
- Reset values: ridx=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, mismatch_cnt=0; FSM in IDLE.
- States: IDLE, ADDR, CAPT, SEND, DONE.
- IDLE: start=1 -> idx:=0, busy:=1, clear mismatch_cnt, go ADDR. start=0 -> stay.
- ADDR: drive ridx=idx (ridx is registered, holds idx); go CAPT.
- CAPT: sample rdata_user, rdata_real, fill_flag[idx] into holding registers; load out_data, set out_valid=1, out_last=(idx==NUM_CELLS-1); go SEND.
- SEND: hold out_valid/out_data/out_last stable while out_ready=0. On out_valid&out_ready: out_valid:=0; if last -> DONE, else idx:=idx+1, go ADDR.
- DONE: done=1 for one cycle, busy:=0, go IDLE. ridx keeps last index.
- start while busy (ADDR..DONE) is ignored, no queuing.
- Index counter 4 bits, never exceeds NUM_CELLS-1; no wrap within a pass.
- restart_n low at any state: immediate return to reset values; partially sent byte is abandoned, out_valid drops asynchronously.
- out_ready high outside SEND has no effect.

## Timing
- start sampled in cycle T -> ridx=0 valid from T+1 (ADDR), capture at T+2, out_valid=1 from T+3.
- Per cell minimum 3 cycles (ADDR, CAPT, SEND with out_ready=1); full 16-cell scan with out_ready tied high: final byte accepted in cycle T+48, done pulses T+49, busy low from T+50.
- Each out_ready=0 cycle in SEND adds exactly one cycle.
- Read-data assumption is fixed: datapath returns data exactly one cycle after ridx changes; capture never occurs in the ridx-change cycle.
- out_data/out_last only change on the CAPT->SEND transition or reset.

## Configuration
- SCAN_MISMATCH_EN defined: in CAPT, if fill_flag[idx]=1 and rdata_user!=rdata_real, mismatch_cnt increments (saturates at 16 by construction); value stable from done until next accepted start.
- SCAN_MISMATCH_EN undefined: comparator and counter omitted, mismatch_cnt tied to 0, rdata_real unused. Stream behaviour identical in both builds.

## Test plan
- Reset then start with out_ready=1, board cell k user value k%4, all filled -> 16 bytes, byte k = {k, 1, k%4}, out_last only on byte 15, done at start+49.
- Backpressure: out_ready low 5 cycles on cell 3 -> out_valid and out_data=0x3B held all 5 cycles, no cell skipped, done at start+54.
- start pulsed again at cycles 10 and 30 of a scan -> ignored, exactly 16 bytes, one done pulse.
- SCAN_MISMATCH_EN: cells 2 and 9 filled with user!=real, cell 5 unfilled with user!=real -> mismatch_cnt=2 at done; undefined build -> 0.
- restart_n asserted during SEND of cell 7 -> out_valid=0, busy=0 immediately; new start after release scans from cell 0.
- NUM_CELLS=4 build -> 4 bytes, out_last on idx 3, done at start+13.

Source files
------------

// File: rtl/board_scan_reader.sv
// Walks every board cell through the datapath read port and streams one byte per cell; optional SCAN_MISMATCH_EN counts filled cells that disagree with the solution.
// Latency: start -> ridx=0 next cycle, first out_valid three cycles after start, minimum three cycles per cell.
// Backpressure: out_valid/out_data/out_last held stable while out_ready is low; each stalled cycle adds one cycle.
module board_scan_reader #(
  parameter int NUM_CELLS = 16
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        start,
  output logic [3:0]  ridx,
  input  logic [2:0]  rdata_user,
  input  logic [2:0]  rdata_real,
  input  logic [15:0] fill_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [4:0]  mismatch_cnt
);

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, SEND, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CELLS - 1);

  state_t     state;
  logic [3:0] idx;

  // ridx is loaded on entry to ADDR so the datapath sees the new index for a full cycle before CAPT.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state     <= IDLE;
      idx       <= '0;
      ridx      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            ridx  <= '0;
            busy  <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: state <= CAPT;
        CAPT: begin
          out_data  <= {idx, fill_flag[idx], rdata_user};
          out_valid <= 1'b1;
          out_last  <= (idx == LAST_IDX);
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              ridx  <= idx + 4'd1;
              state <= ADDR;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_MISMATCH_EN
  // At most NUM_CELLS increments per pass, so five bits never overflow.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n)
      mismatch_cnt <= '0;
    else if (state == IDLE && start)
      mismatch_cnt <= '0;
    else if (state == CAPT && fill_flag[idx] && (rdata_user != rdata_real))
      mismatch_cnt <= mismatch_cnt + 5'd1;
  end
`else
  logic unused_real;
  assign unused_real  = ^rdata_real;
  assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_board_scan_reader.sv
// Directed bench for board_scan_reader: scoreboard of expected stream bytes, full and 4-cell instances.
module tb_board_scan_reader;

  logic        clka = 1'b0;
  logic        restart_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic        out_ready = 1'b1, out_ready2 = 1'b1;
  logic [15:0] fill_flag;
  logic [3:0]  ridx, ridx2;
  logic [2:0]  rdata_user, rdata_real, rdata_user2, rdata_real2;
  logic        out_valid, out_last, busy, done;
  logic        out_valid2, out_last2, busy2, done2;
  logic [7:0]  out_data, out_data2;
  logic [4:0]  mismatch_cnt, mismatch_cnt2;

  logic [2:0]  board_user [16];
  logic [2:0]  board_real [16];
  logic [8:0]  sb [$];
  logic [8:0]  sb2 [$];

  int total = 0, bad = 0, cyc = 0;
  int rx_cnt = 0, done_cnt = 0, done_cyc = 0;
  int rx2_cnt = 0, done2_cnt = 0, done2_cyc = 0;

  board_scan_reader #(.NUM_CELLS(16)) dut (
    .clka(clka), .restart_n(restart_n), .start(start), .ridx(ridx),
    .rdata_user(rdata_user), .rdata_real(rdata_real), .fill_flag(fill_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt)
  );

  board_scan_reader #(.NUM_CELLS(4)) dut4 (
    .clka(clka), .restart_n(restart_n), .start(start2), .ridx(ridx2),
    .rdata_user(rdata_user2), .rdata_real(rdata_real2), .fill_flag(fill_flag),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .busy(busy2), .done(done2), .mismatch_cnt(mismatch_cnt2)
  );

  always #5 clka = ~clka;

  // Datapath model: registered read, data valid one cycle after ridx
  always @(posedge clka) begin
    cyc         <= cyc + 1;
    rdata_user  <= board_user[ridx];
    rdata_real  <= board_real[ridx];
    rdata_user2 <= board_user[ridx2];
    rdata_real2 <= board_real[ridx2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clka) begin
    if (out_valid && out_ready) begin
      rx_cnt++;
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) check("byte", {out_last, out_data}, sb.pop_front());
    end
    if (out_valid2 && out_ready2) begin
      rx2_cnt++;
      check("sb2_nonempty", 32'(sb2.size() != 0), 1);
      if (sb2.size() != 0) check("byte4", {out_last2, out_data2}, sb2.pop_front());
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic start_scan(output int t0);
    for (int k = 0; k < 16; k++)
      sb.push_back({k == 15, 4'(k), fill_flag[k], board_user[k]});
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin tick(); n++; end
    check("done_seen", 32'(done_cnt != base), 1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load_board();
    for (int k = 0; k < 16; k++) begin
      board_user[k] = 3'(k % 4);
      board_real[k] = 3'(k % 4);
    end
    fill_flag = 16'hFFFF;
  endtask

  initial begin
    int t0, d0, r0, exp_mm;
    load_board();
    tick(2);
    @(negedge clka);
    check("rst_ridx", ridx, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch_cnt, 0);
    restart_n = 1'b1;
    tick();

    // Full scan, out_ready held high
    d0 = done_cnt; r0 = rx_cnt;
    start_scan(t0);
    check("busy_after_start", busy, 1);
    check("ridx_after_start", ridx, 0);
    wait_done(d0, 80);
    check("done_cycle", done_cyc, t0 + 49);
    check("busy_after_done", busy, 0);
    check("bytes_full", rx_cnt - r0, 16);
    check("ridx_hold_last", ridx, 15);
    check("mismatch_clean", mismatch_cnt, 0);

    // Backpressure on cell 3, board with mismatches
    board_real[2] = board_user[2] ^ 3'd1;
    board_real[9] = board_user[9] ^ 3'd1;
    board_real[5] = board_user[5] ^ 3'd1;
    fill_flag[5]  = 1'b0;
`ifdef SCAN_MISMATCH_EN
    exp_mm = 2;
`else
    exp_mm = 0;
`endif
    d0 = done_cnt; r0 = rx_cnt;
    start_scan(t0);
    wait_until(t0 + 12);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clka);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'h3B);
      tick();
    end
    out_ready = 1'b1;
    wait_done(d0, 80);
    check("bp_done_cycle", done_cyc, t0 + 54);
    check("bp_bytes", rx_cnt - r0, 16);
    check("mismatch_cnt", mismatch_cnt, exp_mm);
    load_board();

    // start pulses while busy are ignored
    d0 = done_cnt; r0 = rx_cnt;
    start_scan(t0);
    wait_until(t0 + 10);
    start = 1'b1; tick(); start = 1'b0;
    wait_until(t0 + 30);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d0, 80);
    check("ign_done_cycle", done_cyc, t0 + 49);
    tick(10);
    check("ign_bytes", rx_cnt - r0, 16);
    check("ign_done_pulses", done_cnt - d0, 1);
    check("ign_idle", busy, 0);

    // Reset during SEND of cell 7
    r0 = rx_cnt;
    start_scan(t0);
    wait_until(t0 + 24);
    check("pre_rst_valid", out_valid, 1);
    restart_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_bytes", rx_cnt - r0, 7);
    sb.delete();
    tick(2);
    restart_n = 1'b1;
    tick();
    d0 = done_cnt; r0 = rx_cnt;
    start_scan(t0);
    wait_done(d0, 80);
    check("post_rst_done_cycle", done_cyc, t0 + 49);
    check("post_rst_bytes", rx_cnt - r0, 16);

    // Four-cell instance
    for (int k = 0; k < 4; k++)
      sb2.push_back({k == 3, 4'(k), fill_flag[k], board_user[k]});
    d0 = done2_cnt; r0 = rx2_cnt;
    start2 = 1'b1;
    t0 = cyc;
    tick();
    start2 = 1'b0;
    for (int n = 0; n < 40 && done2_cnt == d0; n++) tick();
    check("n4_done_seen", 32'(done2_cnt != d0), 1);
    check("n4_done_cycle", done2_cyc, t0 + 13);
    check("n4_bytes", rx2_cnt - r0, 4);
    check("n4_ridx_last", ridx2, 3);

    check("sb_drained", sb.size(), 0);
    check("sb2_drained", sb2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
